ex_mem_pipe_reg: RTL and testbench
==================================

// Module: ex_mem_pipe_reg
// PURPOSE
// Parametrised, clocked EX/MEM pipeline register with valid/ready handshake, optional skid buffer and flush.
// Sits between the execute stage (ALU, branch adder, dest mux) and the memory stage.
// Adds stall (back-pressure), bubble insertion on flush, branch-taken decode and a stall-cycle counter.
// PARAMETERS
// DATA_W      32  width of adder, ALU result and read-data-2 paths
// REG_ADDR_W  5   width of destination register number
// WB_W        2   width of write-back control field
// SKID        1   1 = two-entry skid buffer (registered in_ready); 0 = single entry
// CNT_W       16  width of saturating stall counter
// PORTS
// clk          in   1           rising-edge clock
// rst          in   1           synchronous, active-high reset
// flush        in   1           kill all held and incoming entries
// in_valid     in   1           EX stage presents an instruction
// in_ready     out  1           stage can accept this cycle
// ctlwb_in     in   WB_W        write-back control
// ctlm_in      in   3           {branch, memread, memwrite}
// adder_in     in   DATA_W      branch target address
// aluzero_in   in   1           ALU zero flag
// aluout_in    in   DATA_W      ALU result
// readdat2_in  in   DATA_W      register read data 2 (store data)
// dest_in      in   REG_ADDR_W  destination register number
// out_valid    out  1           MEM stage entry valid
// out_ready    in   1           MEM stage consumes entry this cycle
// wb_ctlout    out  WB_W        write-back control (0 when !out_valid)
// branch, memread, memwrite  out 1 each  memory control (0 when !out_valid)
// add_result, alu_result, rdata2out  out DATA_W  payload
// zero         out  1           ALU zero flag
// dest_out     out  REG_ADDR_W  destination register number
// pcsrc        out  1           out_valid & branch & zero
// stall_cnt    out  CNT_W       saturating count of stalled cycles
// BEHAVIOUR
// - Reset (sync, rst=1 at edge): state EMPTY, out_valid=0, all payload/control outputs 0, pcsrc=0,
//   stall_cnt=0, in_ready=1. Reset mid-operation discards all held entries.
// - Accept = in_valid & in_ready; issue = out_valid & out_ready. Latency 1 cycle accept->out_valid.
// - Order preserved; no entry lost or duplicated.
// - SKID=1 states: EMPTY (0 held), ONE (main held), TWO (main+skid held).
//   EMPTY: accept->ONE. ONE: accept&!issue->TWO (capture into skid); !accept&issue->EMPTY; else ONE,
//   main reloads on accept&issue. TWO: issue->ONE (skid moves to main); no accept possible.
//   in_ready is a register: 1 in EMPTY/ONE, 0 in TWO.
// - SKID=0: single entry; in_ready = !out_valid | out_ready (combinational); accept&issue same cycle reloads.
// - Flush: next cycle state EMPTY, out_valid=0, in_ready=1; flush overrides simultaneous accept/issue
//   (incoming dropped). rst has priority over flush.
// - Control gating: wb_ctlout, branch, memread, memwrite, pcsrc forced 0 whenever out_valid=0;
//   data payload holds last value (don't care).
// - Payload held stable while out_valid & !out_ready.
// - stall_cnt: +1 each cycle out_valid & !out_ready; saturates at 2^CNT_W-1; cleared only by rst.
// TESTING
// 1 Reset: rst=1 two cycles mid-traffic -> out_valid=0, memwrite=0, in_ready=1, stall_cnt=0.
// 2 Stream: out_ready=1, in_valid=1, aluout_in=1,2,3,4 -> alu_result 1,2,3,4 on consecutive cycles, 1-cycle lag, in_ready stays 1.
// 3 Back-pressure (SKID=1): out_ready=0, push 0x11, 0x22 -> in_ready=0 after 2nd accept, stall_cnt counts;
//   release -> 0x11 then 0x22, no third entry accepted while full.
// 4 Flush with in_valid=1, entry held -> next cycle out_valid=0, memwrite=0, pcsrc=0, pushed entry never appears.
// 5 Branch: ctlm_in=3'b100, aluzero_in=1 -> pcsrc=1 one cycle later; aluzero_in=0 -> pcsrc=0.
// 6 CNT_W=4, out_ready=0 for 20 cycles with entry held -> stall_cnt=15; SKID=0 rerun of 2/3 matches order.

Source files
------------

// File: rtl/ex_mem_pipe_reg_if.sv
// EX->MEM stage bus: EX-side inputs, MEM-side outputs and the stall counter.
// slave is the pipeline register's view; master is the EX/MEM environment's view.
interface ex_mem_pipe_reg_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int WB_W       = 2,
    parameter int CNT_W      = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [WB_W-1:0]       ctlwb_in;
    logic [2:0]            ctlm_in;
    logic [DATA_W-1:0]     adder_in;
    logic                  aluzero_in;
    logic [DATA_W-1:0]     aluout_in;
    logic [DATA_W-1:0]     readdat2_in;
    logic [REG_ADDR_W-1:0] dest_in;

    logic                  out_valid;
    logic                  out_ready;
    logic [WB_W-1:0]       wb_ctlout;
    logic                  branch;
    logic                  memread;
    logic                  memwrite;
    logic [DATA_W-1:0]     add_result;
    logic [DATA_W-1:0]     alu_result;
    logic [DATA_W-1:0]     rdata2out;
    logic                  zero;
    logic [REG_ADDR_W-1:0] dest_out;
    logic                  pcsrc;
    logic [CNT_W-1:0]      stall_cnt;

    modport slave (
        input  in_valid, ctlwb_in, ctlm_in, adder_in, aluzero_in, aluout_in, readdat2_in, dest_in,
        input  out_ready,
        output in_ready, out_valid, wb_ctlout, branch, memread, memwrite,
        output add_result, alu_result, rdata2out, zero, dest_out, pcsrc, stall_cnt
    );

    modport master (
        output in_valid, ctlwb_in, ctlm_in, adder_in, aluzero_in, aluout_in, readdat2_in, dest_in,
        output out_ready,
        input  in_ready, out_valid, wb_ctlout, branch, memread, memwrite,
        input  add_result, alu_result, rdata2out, zero, dest_out, pcsrc, stall_cnt
    );
endinterface

// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register with flush, branch decode and saturating stall counter; 1-cycle latency.
// Back-pressure: SKID=1 gives a two-entry skid with registered in_ready, SKID=0 a single entry with pass-through ready.
module ex_mem_pipe_reg #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int WB_W       = 2,
    parameter int SKID       = 1,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    ex_mem_pipe_reg_if.slave  bus
);
    typedef struct packed {
        logic [WB_W-1:0]       wb;
        logic [2:0]            m;
        logic [DATA_W-1:0]     add;
        logic                  zero;
        logic [DATA_W-1:0]     alu;
        logic [DATA_W-1:0]     rd2;
        logic [REG_ADDR_W-1:0] dest;
    } ent_t;

    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

    state_t           state, state_nxt;
    ent_t             main_q, skid_q, in_ent;
    logic             in_ready_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic             out_valid, accept, issue;
    logic             load_main, load_skid, main_from_skid;

    assign in_ent = '{wb: bus.ctlwb_in, m: bus.ctlm_in, add: bus.adder_in, zero: bus.aluzero_in,
                      alu: bus.aluout_in, rd2: bus.readdat2_in, dest: bus.dest_in};

    assign out_valid   = (state != S_EMPTY);
    assign bus.in_ready = (SKID != 0) ? in_ready_q : (!out_valid || bus.out_ready);
    assign accept      = bus.in_valid && bus.in_ready;
    assign issue       = out_valid && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state      <= state_nxt;
            in_ready_q <= (state_nxt != S_TWO);
        end
    end

    always_comb begin
        state_nxt      = state;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state)
            S_EMPTY: begin
                if (accept) begin
                    state_nxt = S_ONE;
                    load_main = 1'b1;
                end
            end
            S_ONE: begin
                if (accept && issue) begin
                    load_main = 1'b1;
                end else if (accept) begin
                    // only reachable with SKID=1: pass-through ready blocks this case otherwise
                    state_nxt = S_TWO;
                    load_skid = 1'b1;
                end else if (issue) begin
                    state_nxt = S_EMPTY;
                end
            end
            S_TWO: begin
                if (issue) begin
                    state_nxt      = S_ONE;
                    main_from_skid = 1'b1;
                end
            end
            default: state_nxt = S_EMPTY;
        endcase
        if (flush) state_nxt = S_EMPTY;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main)           main_q <= in_ent;
            else if (main_from_skid) main_q <= skid_q;
            if (load_skid)           skid_q <= in_ent;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (out_valid && !bus.out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    // control fields are gated so a bubble can never trigger a write or a branch
    assign bus.out_valid  = out_valid;
    assign bus.wb_ctlout  = out_valid ? main_q.wb : '0;
    assign bus.branch     = out_valid && main_q.m[2];
    assign bus.memread    = out_valid && main_q.m[1];
    assign bus.memwrite   = out_valid && main_q.m[0];
    assign bus.pcsrc      = out_valid && main_q.m[2] && main_q.zero;
    assign bus.add_result = main_q.add;
    assign bus.alu_result = main_q.alu;
    assign bus.rdata2out  = main_q.rd2;
    assign bus.zero       = main_q.zero;
    assign bus.dest_out   = main_q.dest;
    assign bus.stall_cnt  = stall_cnt_q;
endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Directed bench: instance a is SKID=1/CNT_W=4, instance b is SKID=0/CNT_W=4.
module tb_ex_mem_pipe_reg;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    int   tests_run = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    ex_mem_pipe_reg_if #(.DATA_W(32), .REG_ADDR_W(5), .WB_W(2), .CNT_W(4)) a_if ();
    ex_mem_pipe_reg_if #(.DATA_W(32), .REG_ADDR_W(5), .WB_W(2), .CNT_W(4)) b_if ();

    ex_mem_pipe_reg #(.DATA_W(32), .REG_ADDR_W(5), .WB_W(2), .SKID(1), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst), .flush(flush), .bus(a_if)
    );
    ex_mem_pipe_reg #(.DATA_W(32), .REG_ADDR_W(5), .WB_W(2), .SKID(0), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .flush(flush), .bus(b_if)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [31:0] alu, input logic [2:0] m, input logic z);
        a_if.in_valid = v; a_if.aluout_in = alu; a_if.ctlm_in = m; a_if.aluzero_in = z;
        a_if.ctlwb_in = 2'b11; a_if.adder_in = alu + 32'h100; a_if.readdat2_in = ~alu; a_if.dest_in = alu[4:0];
    endtask

    task automatic drive_b(input logic v, input logic [31:0] alu);
        b_if.in_valid = v; b_if.aluout_in = alu; b_if.ctlm_in = 3'b010; b_if.aluzero_in = 1'b0;
        b_if.ctlwb_in = 2'b01; b_if.adder_in = 32'h0; b_if.readdat2_in = 32'h0; b_if.dest_in = 5'd1;
    endtask

    task automatic do_reset();
        rst = 1'b1; tick(); tick(); rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++; if (a_if.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %0b want 0", a_if.out_valid); end
        tests_run++; if (a_if.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got %0b want 1", a_if.in_ready); end
        tests_run++; if (a_if.alu_result !== 32'h0) begin failures++; $display("FAIL reset_alu_result got %h want 0", a_if.alu_result); end
        // load two stores against a stalled consumer, then reset mid-traffic
        a_if.out_ready = 1'b0;
        drive_a(1'b1, 32'h55, 3'b001, 1'b0); tick(); tick();
        drive_a(1'b0, 32'h0, 3'b000, 1'b0);
        tests_run++; if (a_if.memwrite !== 1'b1) begin failures++; $display("FAIL pre_reset_memwrite got %0b want 1", a_if.memwrite); end
        tests_run++; if (a_if.stall_cnt !== 4'd1) begin failures++; $display("FAIL pre_reset_stall_cnt got %0d want 1", a_if.stall_cnt); end
        do_reset();
        tests_run++; if (a_if.out_valid !== 1'b0) begin failures++; $display("FAIL midreset_out_valid got %0b want 0", a_if.out_valid); end
        tests_run++; if (a_if.memwrite !== 1'b0) begin failures++; $display("FAIL midreset_memwrite got %0b want 0", a_if.memwrite); end
        tests_run++; if (a_if.in_ready !== 1'b1) begin failures++; $display("FAIL midreset_in_ready got %0b want 1", a_if.in_ready); end
        tests_run++; if (a_if.stall_cnt !== 4'd0) begin failures++; $display("FAIL midreset_stall_cnt got %0d want 0", a_if.stall_cnt); end
    endtask

    task automatic test_stream();
        a_if.out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive_a(1'b1, 32'(i), 3'b010, 1'b0);
            tick();
            tests_run++; if (a_if.alu_result !== 32'(i)) begin failures++; $display("FAIL stream_alu_%0d got %0d want %0d", i, a_if.alu_result, i); end
            tests_run++; if (a_if.in_ready !== 1'b1 || a_if.out_valid !== 1'b1) begin failures++; $display("FAIL stream_rdy_vld_%0d got %0b%0b want 11", i, a_if.in_ready, a_if.out_valid); end
        end
        tests_run++; if (a_if.memread !== 1'b1 || a_if.wb_ctlout !== 2'b11) begin failures++; $display("FAIL stream_ctl got %0b/%0b want 1/11", a_if.memread, a_if.wb_ctlout); end
        drive_a(1'b0, 32'h0, 3'b000, 1'b0); tick();
        tests_run++; if (a_if.out_valid !== 1'b0 || a_if.wb_ctlout !== 2'b00) begin failures++; $display("FAIL stream_drain got %0b/%0b want 0/00", a_if.out_valid, a_if.wb_ctlout); end
        tests_run++; if (a_if.stall_cnt !== 4'd0) begin failures++; $display("FAIL stream_stall_cnt got %0d want 0", a_if.stall_cnt); end
    endtask

    task automatic test_backpressure();
        a_if.out_ready = 1'b0;
        drive_a(1'b1, 32'h11, 3'b000, 1'b0); tick();
        tests_run++; if (a_if.in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_after_1 got %0b want 1", a_if.in_ready); end
        drive_a(1'b1, 32'h22, 3'b000, 1'b0); tick();
        tests_run++; if (a_if.in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_after_2 got %0b want 0", a_if.in_ready); end
        tests_run++; if (a_if.alu_result !== 32'h11) begin failures++; $display("FAIL bp_head got %h want 11", a_if.alu_result); end
        tests_run++; if (a_if.stall_cnt !== 4'd1) begin failures++; $display("FAIL bp_stall_1 got %0d want 1", a_if.stall_cnt); end
        drive_a(1'b1, 32'h33, 3'b000, 1'b0); tick();
        tests_run++; if (a_if.stall_cnt !== 4'd2 || a_if.alu_result !== 32'h11) begin failures++; $display("FAIL bp_hold got %0d/%h want 2/11", a_if.stall_cnt, a_if.alu_result); end
        a_if.out_ready = 1'b1; tick();
        drive_a(1'b0, 32'h0, 3'b000, 1'b0);
        tests_run++; if (a_if.alu_result !== 32'h22 || a_if.out_valid !== 1'b1) begin failures++; $display("FAIL bp_second got %h/%0b want 22/1", a_if.alu_result, a_if.out_valid); end
        tests_run++; if (a_if.stall_cnt !== 4'd2) begin failures++; $display("FAIL bp_stall_release got %0d want 2", a_if.stall_cnt); end
        tick();
        tests_run++; if (a_if.out_valid !== 1'b0) begin failures++; $display("FAIL bp_no_third got %0b want 0 (alu %h)", a_if.out_valid, a_if.alu_result); end
    endtask

    task automatic test_flush();
        a_if.out_ready = 1'b0;
        drive_a(1'b1, 32'h77, 3'b101, 1'b1); tick();
        tests_run++; if (a_if.pcsrc !== 1'b1 || a_if.memwrite !== 1'b1) begin failures++; $display("FAIL flush_held got %0b/%0b want 1/1", a_if.pcsrc, a_if.memwrite); end
        flush = 1'b1;
        drive_a(1'b1, 32'h88, 3'b001, 1'b0); tick();
        flush = 1'b0;
        drive_a(1'b0, 32'h0, 3'b000, 1'b0);
        tests_run++; if (a_if.out_valid !== 1'b0 || a_if.memwrite !== 1'b0 || a_if.pcsrc !== 1'b0) begin failures++; $display("FAIL flush_bubble got v%0b mw%0b pc%0b want 000", a_if.out_valid, a_if.memwrite, a_if.pcsrc); end
        tests_run++; if (a_if.in_ready !== 1'b1) begin failures++; $display("FAIL flush_in_ready got %0b want 1", a_if.in_ready); end
        a_if.out_ready = 1'b1; tick(); tick();
        tests_run++; if (a_if.out_valid !== 1'b0) begin failures++; $display("FAIL flush_dropped got %0b want 0 (alu %h)", a_if.out_valid, a_if.alu_result); end
    endtask

    task automatic test_branch();
        a_if.out_ready = 1'b1;
        drive_a(1'b1, 32'h5, 3'b100, 1'b1); tick();
        tests_run++; if (a_if.pcsrc !== 1'b1 || a_if.branch !== 1'b1) begin failures++; $display("FAIL branch_taken got %0b/%0b want 1/1", a_if.pcsrc, a_if.branch); end
        tests_run++; if (a_if.add_result !== 32'h105) begin failures++; $display("FAIL branch_target got %h want 105", a_if.add_result); end
        drive_a(1'b1, 32'h6, 3'b100, 1'b0); tick();
        tests_run++; if (a_if.pcsrc !== 1'b0 || a_if.branch !== 1'b1) begin failures++; $display("FAIL branch_not_taken got %0b/%0b want 0/1", a_if.pcsrc, a_if.branch); end
        drive_a(1'b1, 32'h7, 3'b000, 1'b1); tick();
        tests_run++; if (a_if.pcsrc !== 1'b0) begin failures++; $display("FAIL branch_nobranch got %0b want 0", a_if.pcsrc); end
        drive_a(1'b0, 32'h0, 3'b000, 1'b0); tick();
        tests_run++; if (a_if.pcsrc !== 1'b0 || a_if.branch !== 1'b0) begin failures++; $display("FAIL branch_idle got %0b/%0b want 0/0", a_if.pcsrc, a_if.branch); end
    endtask

    task automatic test_stall_saturate();
        do_reset();
        a_if.out_ready = 1'b0;
        drive_a(1'b1, 32'hAB, 3'b000, 1'b0); tick();
        drive_a(1'b0, 32'h0, 3'b000, 1'b0);
        for (int i = 0; i < 20; i++) tick();
        tests_run++; if (a_if.stall_cnt !== 4'd15) begin failures++; $display("FAIL sat_stall_cnt got %0d want 15", a_if.stall_cnt); end
        tests_run++; if (a_if.alu_result !== 32'hAB || a_if.out_valid !== 1'b1) begin failures++; $display("FAIL sat_held got %h/%0b want ab/1", a_if.alu_result, a_if.out_valid); end
        a_if.out_ready = 1'b1; tick();
        tests_run++; if (a_if.stall_cnt !== 4'd15 || a_if.out_valid !== 1'b0) begin failures++; $display("FAIL sat_release got %0d/%0b want 15/0", a_if.stall_cnt, a_if.out_valid); end
    endtask

    task automatic test_skid0_stream();
        do_reset();
        b_if.out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive_b(1'b1, 32'(i));
            tick();
            tests_run++; if (b_if.alu_result !== 32'(i) || b_if.in_ready !== 1'b1) begin failures++; $display("FAIL s0_stream_%0d got %0d/%0b want %0d/1", i, b_if.alu_result, b_if.in_ready, i); end
        end
        drive_b(1'b0, 32'h0); tick();
        tests_run++; if (b_if.out_valid !== 1'b0) begin failures++; $display("FAIL s0_stream_drain got %0b want 0", b_if.out_valid); end
    endtask

    task automatic test_skid0_backpressure();
        b_if.out_ready = 1'b0;
        drive_b(1'b1, 32'h11); tick();
        drive_b(1'b1, 32'h22);
        tests_run++; if (b_if.in_ready !== 1'b0) begin failures++; $display("FAIL s0_bp_ready got %0b want 0", b_if.in_ready); end
        tick();
        tests_run++; if (b_if.alu_result !== 32'h11 || b_if.stall_cnt !== 4'd1) begin failures++; $display("FAIL s0_bp_hold got %h/%0d want 11/1", b_if.alu_result, b_if.stall_cnt); end
        b_if.out_ready = 1'b1;
        #1;
        tests_run++; if (b_if.in_ready !== 1'b1) begin failures++; $display("FAIL s0_bp_passthru got %0b want 1", b_if.in_ready); end
        tick();
        drive_b(1'b0, 32'h0);
        tests_run++; if (b_if.alu_result !== 32'h22 || b_if.out_valid !== 1'b1) begin failures++; $display("FAIL s0_bp_second got %h/%0b want 22/1", b_if.alu_result, b_if.out_valid); end
        tick();
        tests_run++; if (b_if.out_valid !== 1'b0 || b_if.stall_cnt !== 4'd1) begin failures++; $display("FAIL s0_bp_end got %0b/%0d want 0/1", b_if.out_valid, b_if.stall_cnt); end
    endtask

    initial begin
        drive_a(1'b0, 32'h0, 3'b000, 1'b0);
        drive_b(1'b0, 32'h0);
        a_if.out_ready = 1'b0;
        b_if.out_ready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_branch();
        test_stall_saturate();
        test_skid0_stream();
        test_skid0_backpressure();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end
endmodule
